pipem_alu: RTL and testbench

Execute-stage arithmetic block for the 5-stage PIPEM MIPS core. It merges ALU-control decoding (ALUOp/opcode/funct → operation) and the 32-bit datapath ALU into one unit, including HI/LO registers for multiply/divide. All results are combinational except HI/LO, which update on the clock edge. It sits between the forwarding/OrigALU muxes and the EX/MEM register.

---
 rtl/pipem_alu.sv | 164 ++++++++++++++++
 tb/tb_pipem_alu.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipem_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipem_alu: PIPEM execute-stage ALU with ALU-control decode and HI/LO.      |
// | Optional multiply/divide + HI/LO built when ALU_MULDIV_EN is defined.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipem_alu (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [1:0]  iALUOp,
  input  logic [5:0]  iOpcode,
  input  logic [5:0]  iFunct,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [4:0]  iShamt,
  output logic [31:0] oALUresult,
  output logic        oZero,
  output logic        oOverflow
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_addOvf;
  logic        w_subOvf;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_result;
  logic        w_ovf;

  assign w_sum    = iA + iB;
  assign w_diff   = iA - iB;
  assign w_addOvf = (iA[31] == iB[31]) && (w_sum[31] != iA[31]);
  assign w_subOvf = (iA[31] != iB[31]) && (w_diff[31] != iA[31]);
  assign w_slt    = $signed(iA) < $signed(iB);
  assign w_sltu   = iA < iB;

`ifdef ALU_MULDIV_EN
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_prodS;
  logic [63:0] w_prodU;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_absBSafe;
  logic [31:0] w_bSafe;
  logic [31:0] w_qMag;
  logic [31:0] w_rMag;
  logic [31:0] w_quotS;
  logic [31:0] w_remS;
  logic [31:0] w_quotU;
  logic [31:0] w_remU;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign w_prodS = {{32{iA[31]}}, iA} * {{32{iB[31]}}, iB};
  assign w_prodU = {32'b0, iA} * {32'b0, iB};

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign w_absA     = iA[31] ? -iA : iA;
  assign w_absB     = iB[31] ? -iB : iB;
  assign w_absBSafe = (w_absB == 32'd0) ? 32'd1 : w_absB;
  assign w_bSafe    = (iB == 32'd0) ? 32'd1 : iB;
  assign w_qMag     = w_absA / w_absBSafe;
  assign w_rMag     = w_absA % w_absBSafe;
  assign w_quotS    = (iA[31] ^ iB[31]) ? -w_qMag : w_qMag;
  assign w_remS     = iA[31] ? -w_rMag : w_rMag;
  assign w_quotU    = iA / w_bSafe;
  assign w_remU     = iA % w_bSafe;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (iALUOp == 2'b10) begin
      case (iFunct)
        6'h11: r_hi <= iA;
        6'h13: r_lo <= iA;
        6'h18: {r_hi, r_lo} <= w_prodS;
        6'h19: {r_hi, r_lo} <= w_prodU;
        6'h1A: if (iB != 32'd0) begin
          r_lo <= w_quotS;
          r_hi <= w_remS;
        end
        6'h1B: if (iB != 32'd0) begin
          r_lo <= w_quotU;
          r_hi <= w_remU;
        end
        default: ;
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, iCLK, iRST};
`endif

  always_comb begin
    w_result = 32'd0;
    w_ovf    = 1'b0;
    case (iALUOp)
      2'b00: begin
        w_result = w_sum;
        w_ovf    = w_addOvf;
      end
      2'b01: begin
        w_result = w_diff;
        w_ovf    = w_subOvf;
      end
      2'b11: begin
        case (iOpcode)
          6'h08: begin
            w_result = w_sum;
            w_ovf    = w_addOvf;
          end
          6'h0A:   w_result = {31'b0, w_slt};
          6'h0B:   w_result = {31'b0, w_sltu};
          6'h0C:   w_result = iA & iB;
          6'h0D:   w_result = iA | iB;
          6'h0E:   w_result = iA ^ iB;
          6'h0F:   w_result = iB;
          default: w_result = w_sum;
        endcase
      end
      2'b10: begin
        case (iFunct)
          6'h00: w_result = iB << iShamt;
          6'h02: w_result = iB >> iShamt;
          6'h03: w_result = $signed(iB) >>> iShamt;
          6'h04: w_result = iB << iA[4:0];
          6'h06: w_result = iB >> iA[4:0];
          6'h07: w_result = $signed(iB) >>> iA[4:0];
          6'h08, 6'h09, 6'h21: w_result = w_sum;
          6'h20: begin
            w_result = w_sum;
            w_ovf    = w_addOvf;
          end
          6'h22: begin
            w_result = w_diff;
            w_ovf    = w_subOvf;
          end
          6'h23: w_result = w_diff;
          6'h24: w_result = iA & iB;
          6'h25: w_result = iA | iB;
          6'h26: w_result = iA ^ iB;
          6'h27: w_result = ~(iA | iB);
          6'h2A: w_result = {31'b0, w_slt};
          6'h2B: w_result = {31'b0, w_sltu};
`ifdef ALU_MULDIV_EN
          6'h10: w_result = r_hi;
          6'h12: w_result = r_lo;
          6'h11, 6'h13: w_result = iA;
`endif
          default: w_result = 32'd0;
        endcase
      end
      default: ;
    endcase
  end

  assign oALUresult = w_result;
  assign oZero      = (w_result == 32'd0);
  assign oOverflow  = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipem_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipem_alu: randomized scoreboard bench for pipem_alu against a         |
// | longint reference model; honours ALU_MULDIV_EN.  Rev 1.0                   |
// +----------------------------------------------------------------------------+
module tb_pipem_alu;

`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic        iCLK;
  logic        iRST;
  logic [1:0]  iALUOp;
  logic [5:0]  iOpcode;
  logic [5:0]  iFunct;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [4:0]  iShamt;
  logic [31:0] oALUresult;
  logic        oZero;
  logic        oOverflow;

  pipem_alu dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iALUOp     (iALUOp),
    .iOpcode    (iOpcode),
    .iFunct     (iFunct),
    .iA         (iA),
    .iB         (iB),
    .iShamt     (iShamt),
    .oALUresult (oALUresult),
    .oZero      (oZero),
    .oOverflow  (oOverflow)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  logic        sValid;
  int          nPass;
  int          nTotal;
  int          itemId;
  logic [31:0] mHi;
  logic [31:0] mLo;

  function automatic bit fits32(input longint v);
    logic [31:0] low;
    longint      e;
    low = v[31:0];
    e   = $signed(low);
    return v == e;
  endfunction

  // HI/LO reads use the model registers as they stand when the item is issued.
  function automatic void refModel(input logic [1:0] op, input logic [5:0] opc,
                                   input logic [5:0] fn, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output logic [31:0] res, output logic ov);
    longint sa, sb, s, d;
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb;
    d  = sa - sb;
    res = 32'd0;
    ov  = 1'b0;
    case (op)
      2'd0: begin res = 32'(s); ov = !fits32(s); end
      2'd1: begin res = 32'(d); ov = !fits32(d); end
      2'd3: case (opc)
        6'h08: begin res = 32'(s); ov = !fits32(s); end
        6'h0A: res = (sa < sb) ? 32'd1 : 32'd0;
        6'h0B: res = (a < b) ? 32'd1 : 32'd0;
        6'h0C: res = a & b;
        6'h0D: res = a | b;
        6'h0E: res = a ^ b;
        6'h0F: res = b;
        default: res = 32'(s);
      endcase
      default: case (fn)
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: res = 32'(sb >>> sh);
        6'h04: res = b << a[4:0];
        6'h06: res = b >> a[4:0];
        6'h07: res = 32'(sb >>> a[4:0]);
        6'h08, 6'h09, 6'h21: res = 32'(s);
        6'h20: begin res = 32'(s); ov = !fits32(s); end
        6'h22: begin res = 32'(d); ov = !fits32(d); end
        6'h23: res = 32'(d);
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        6'h10: res = MULDIV ? hi : 32'd0;
        6'h12: res = MULDIV ? lo : 32'd0;
        6'h11, 6'h13: res = MULDIV ? a : 32'd0;
        default: res = 32'd0;
      endcase
    endcase
  endfunction

  task automatic updHiLo(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    if (!rst) begin
      mHi = 32'd0;
      mLo = 32'd0;
    end else if (MULDIV && op == 2'd2) begin
      case (fn)
        6'h11: mHi = a;
        6'h13: mLo = a;
        6'h18: begin p = sa * sb; mHi = p[63:32]; mLo = p[31:0]; end
        6'h19: begin p = ua * ub; mHi = p[63:32]; mLo = p[31:0]; end
        6'h1A: if (b != 0) begin mLo = 32'(sa / sb); mHi = 32'(sa % sb); end
        6'h1B: if (b != 0) begin mLo = a / b; mHi = a % b; end
        default: ;
      endcase
    end
  endtask

  // k=1 pushes the hand-derived constants instead of the model's answer.
  task automatic issue(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic rst, input bit k, input logic [31:0] kRes, input logic kOv);
    exp_t        e;
    logic [31:0] r;
    logic        o;
    @(posedge iCLK);
    #1;
    iALUOp  = op;
    iOpcode = opc;
    iFunct  = fn;
    iA      = a;
    iB      = b;
    iShamt  = sh;
    iRST    = rst;
    refModel(op, opc, fn, a, b, sh, mHi, mLo, r, o);
    if (k) begin
      r = kRes;
      o = kOv;
    end
    e.res = r;
    e.z   = (r == 32'd0);
    e.ov  = o;
    e.id  = itemId;
    itemId++;
    sbq.push_back(e);
    sValid = 1'b1;
    updHiLo(rst, op, fn, a, b);
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s item %0d: got %h expected %h", name, id, act, exp);
  endtask

  always @(negedge iCLK) begin
    if (sValid) begin
      if (sbq.size() == 0) begin
        nTotal++;
        $display("FAIL scoreboard_empty: got output with no expected entry");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", e.id, oALUresult, e.res);
        chk("zero", e.id, {31'b0, oZero}, {31'b0, e.z});
        chk("overflow", e.id, {31'b0, oOverflow}, {31'b0, e.ov});
      end
    end
  end

  function automatic logic [31:0] pickOperand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    logic [5:0] fnList [28];
    logic [5:0] fn, opc;
    nPass  = 0;
    nTotal = 0;
    itemId = 0;
    sValid = 1'b0;
    mHi    = 32'd0;
    mLo    = 32'd0;
    iRST   = 1'b0;
    iALUOp = 2'd0; iOpcode = 6'd0; iFunct = 6'd0;
    iA = 32'd0; iB = 32'd0; iShamt = 5'd0;
    fnList = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20, 6'h21,
               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h11,
               6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
    repeat (2) @(posedge iCLK);

    // Reset state: bubble gives 0/zero, HI/LO read back as 0.
    issue(2'd0, 6'h00, 6'h00, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h10, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h12, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);

    issue(2'd2, 6'h00, 6'h20, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1, 1, 32'h80000000, 1'b1);
    issue(2'd2, 6'h00, 6'h21, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1, 1, 32'h80000000, 1'b0);
    issue(2'd2, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1, 1, 32'd1, 1'b0);
    issue(2'd2, 6'h00, 6'h2B, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h03, 32'hFFFFFFFF, 32'h80000000, 5'd4, 1'b1, 1, 32'hF8000000, 1'b0);
    issue(2'd3, 6'h0D, 6'h00, 32'h000000F0, 32'h0000000F, 5'd0, 1'b1, 1, 32'h000000FF, 1'b0);
    issue(2'd3, 6'h0F, 6'h00, 32'h000000F0, 32'h12340000, 5'd0, 1'b1, 1, 32'h12340000, 1'b0);
    issue(2'd1, 6'h00, 6'h00, 32'h55, 32'h55, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd3, 6'h08, 6'h00, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b1, 1, 32'h7FFFFFFF, 1'b1);

`ifdef ALU_MULDIV_EN
    issue(2'd2, 6'h00, 6'h18, 32'hFFFFFFFD, 32'd7, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h12, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'hFFFFFFEB, 1'b0);
    issue(2'd2, 6'h00, 6'h10, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'hFFFFFFFF, 1'b0);
    issue(2'd2, 6'h00, 6'h1A, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h1B, 32'h12345678, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h12, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'hFFFFFFFD, 1'b0);
    issue(2'd2, 6'h00, 6'h10, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'hFFFFFFFF, 1'b0);
    // Reset wins over a simultaneous mthi.
    issue(2'd2, 6'h00, 6'h11, 32'hDEADBEEF, 32'd0, 5'd0, 1'b0, 1, 32'hDEADBEEF, 1'b0);
    issue(2'd2, 6'h00, 6'h10, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h12, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h12, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'h80000000, 1'b0);
    issue(2'd2, 6'h00, 6'h10, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
`else
    issue(2'd2, 6'h00, 6'h18, 32'hFFFFFFFD, 32'd7, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h12, 32'd0, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
    issue(2'd2, 6'h00, 6'h11, 32'hDEADBEEF, 32'd0, 5'd0, 1'b1, 1, 32'd0, 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      fn  = ($urandom_range(4) == 0) ? 6'($urandom) : fnList[$urandom_range(27)];
      opc = ($urandom_range(4) == 0) ? 6'($urandom) : 6'(8 + $urandom_range(7));
      issue(2'($urandom), opc, fn, pickOperand(), pickOperand(), 5'($urandom),
            ($urandom_range(19) == 0) ? 1'b0 : 1'b1, 0, 32'd0, 1'b0);
    end

    @(posedge iCLK);
    #1;
    sValid = 1'b0;
    for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge iCLK);
    if (sbq.size() != 0) begin
      nTotal++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
`default_nettype wire
